// File: rtl/voting_round_ctrl.sv
// Voting round controller: round-robin ballot intake, yes/no tally and majority decision.
// Optional forced close after TIMEOUT_CYCLES collect cycles when VOTE_TIMEOUT_EN is defined.
module voting_round_ctrl #(
  parameter int unsigned NUM_VOTERS     = 15,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  close_i,
  input  logic                  tie_break_i,
  input  logic [NUM_VOTERS-1:0] vote_valid_i,
  input  logic [NUM_VOTERS-1:0] vote_bit_i,
  output logic [NUM_VOTERS-1:0] vote_ready_o,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic                  result_o,
  output logic [CNT_W-1:0]      yes_count_o,
  output logic [CNT_W-1:0]      no_count_o
);

  localparam int unsigned IdxW = (NUM_VOTERS > 1) ? $clog2(NUM_VOTERS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDecide
  } state_e;

  state_e                  state_q;
  logic [NUM_VOTERS-1:0]   voted_q;
  logic [IdxW-1:0]         rr_q;
  logic [CNT_W-1:0]        yes_q;
  logic [CNT_W-1:0]        no_q;
  logic                    result_q;
  logic                    result_valid_q;

  logic [NUM_VOTERS-1:0]   eligible;
  logic [NUM_VOTERS-1:0]   grant_oh;
  logic [IdxW-1:0]         grant_idx;
  logic                    grant_found;
  logic                    all_voted;
  logic                    timeout_hit;
  logic                    close_round;
  logic [IdxW-1:0]         rr_d;

  assign eligible = vote_valid_i & ~voted_q & {NUM_VOTERS{state_q == StCollect}};

  // First pass searches [rr_q, N-1]; second pass wraps to the lowest eligible index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = int'(NUM_VOTERS) - 1; i >= 0; i--) begin
      if (eligible[i] && (i >= int'(rr_q))) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
    if (!grant_found) begin
      for (int i = int'(NUM_VOTERS) - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_found = 1'b1;
          grant_idx   = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign rr_d      = (grant_idx == IdxW'(NUM_VOTERS - 1)) ? '0 : grant_idx + IdxW'(1);
  assign all_voted = &(voted_q | grant_oh);

`ifdef VOTE_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmrW-1:0] tmr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      tmr_q <= '0;
    end else if (state_q == StCollect) begin
      tmr_q <= tmr_q + TmrW'(1);
    end
  end

  assign timeout_hit = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  assign close_round = all_voted | close_i | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      voted_q        <= '0;
      rr_q           <= '0;
      yes_q          <= '0;
      no_q           <= '0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StCollect;
            voted_q  <= '0;
            rr_q     <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            result_q <= 1'b0;
          end
        end
        StCollect: begin
          if (grant_found) begin
            voted_q <= voted_q | grant_oh;
            rr_q    <= rr_d;
            if (vote_bit_i[grant_idx]) begin
              yes_q <= yes_q + CNT_W'(1);
            end else begin
              no_q <= no_q + CNT_W'(1);
            end
          end
          if (close_round) begin
            state_q <= StDecide;
          end
        end
        StDecide: begin
          result_q       <= (yes_q > no_q) | ((yes_q == no_q) & tie_break_i);
          result_valid_q <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vote_ready_o   = grant_oh;
  assign busy_o         = (state_q != StIdle);
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign yes_count_o    = yes_q;
  assign no_count_o     = no_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(vote_ready_o));
  a_tally_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, yes_q} + {1'b0, no_q}) <= (CNT_W + 1)'(NUM_VOTERS));

endmodule

// File: tb/tb_voting_round_ctrl.sv
// Randomized and directed bench for voting_round_ctrl against a per-round behavioural model.
module tb_voting_round_ctrl;
  localparam int N  = 15;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, close, tie;
  logic [N-1:0]  vv, vb, vr;
  logic          busy, rv, res;
  logic [CW-1:0] yc, nc;

  always #5 clk = ~clk;

  voting_round_ctrl #(
    .NUM_VOTERS    (N),
    .CNT_W         (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .close_i       (close),
    .tie_break_i   (tie),
    .vote_valid_i  (vv),
    .vote_bit_i    (vb),
    .vote_ready_o  (vr),
    .busy_o        (busy),
    .result_valid_o(rv),
    .result_o      (res),
    .yes_count_o   (yc),
    .no_count_o    (nc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: round phase 0=idle, 1=collecting, 2=deciding.
  int m_phase, m_ptr, m_yes, m_no, m_tcnt;
  bit m_voted[N];
  bit m_res, m_rv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    int idx;
    if (m_phase != 1) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (vv[idx] && !m_voted[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_yes = 0; m_no = 0; m_tcnt = 0;
    m_res = 0; m_rv = 0;
    for (int i = 0; i < N; i++) m_voted[i] = 0;
  endtask

  // Inputs are set at posedge+1; check grant mid-cycle, advance model at the edge, check state.
  task automatic cycle();
    int g;
    bit all, to;
    logic [N-1:0] exp_vr;
    #2;
    g = exp_grant();
    exp_vr = '0;
    if (g >= 0) exp_vr[g] = 1'b1;
    check("vote_ready", 32'(vr), 32'(exp_vr));
    check("busy", 32'(busy), 32'(m_phase != 0));
    @(posedge clk);
    case (m_phase)
      0: begin
        m_rv = 0;
        if (start) begin
          m_phase = 1; m_ptr = 0; m_yes = 0; m_no = 0; m_res = 0; m_tcnt = 0;
          for (int i = 0; i < N; i++) m_voted[i] = 0;
        end
      end
      1: begin
        m_rv = 0;
        if (g >= 0) begin
          m_voted[g] = 1;
          if (vb[g]) m_yes++; else m_no++;
          m_ptr = (g + 1) % N;
        end
        all = 1;
        for (int i = 0; i < N; i++) if (!m_voted[i]) all = 0;
`ifdef VOTE_TIMEOUT_EN
        to = (m_tcnt == TO - 1);
        m_tcnt++;
`else
        to = 0;
`endif
        if (all || close || to) m_phase = 2;
      end
      default: begin
        m_res = (m_yes > m_no) || ((m_yes == m_no) && tie);
        m_rv = 1;
        m_phase = 0;
      end
    endcase
    #1;
    check("result_valid", 32'(rv), 32'(m_rv));
    check("result", 32'(res), 32'(m_res));
    check("yes_count", 32'(yc), 32'(m_yes));
    check("no_count", 32'(nc), 32'(m_no));
  endtask

  task automatic start_round();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_round();
    vv = '0;
    close = 1'b0;
    while (m_phase != 0) cycle();
  endtask

  initial begin
    rst = 1'b1; start = 0; close = 0; tie = 0; vv = '0; vb = '0;
    model_reset();
    #1;
    check("reset_ready", 32'(vr), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rv", 32'(rv), 0);
    check("reset_yes", 32'(yc), 0);
    @(posedge clk); #1 rst = 1'b0;
    cycle();

    // All voters, 0x01FF: grants 0..14 back to back.
    start_round();
    vv = '1; vb = 15'h01FF;
    repeat (15) cycle();
    check("all_phase_decide", 32'(m_phase), 2);
    vv = '0;
    cycle();
    check("all_rv", 32'(rv), 1);
    check("all_yes", 32'(yc), 9);
    check("all_no", 32'(nc), 6);
    check("all_res", 32'(res), 1);
    cycle();
    check("all_rv_pulse", 32'(rv), 0);

    // Ties with voter 14 idle and explicit close.
    for (int t = 1; t >= 0; t--) begin
      tie = t[0];
      start_round();
      vv = 15'h3FFF; vb = 15'h007F;
      repeat (14) cycle();
      vv = '0; close = 1'b1;
      cycle();
      close = 1'b0;
      cycle();
      check("tie_res", 32'(res), 32'(t));
      check("tie_yes", 32'(yc), 7);
      check("tie_no", 32'(nc), 7);
    end

    // Voter 3 toggles its ballot but counts once.
    start_round();
    vv = 15'h0028; vb = '0;
    for (int i = 0; i < 4; i++) begin
      vb[3] = ~vb[3];
      cycle();
    end
    close = 1'b1; cycle(); close = 1'b0;
    cycle();
    check("dup_sum", 32'(yc) + 32'(nc), 2);

    // Empty round closed on the third collect cycle.
    tie = 1'b1;
    start_round();
    vv = '0;
    cycle(); cycle();
    close = 1'b1; cycle(); close = 1'b0;
    cycle();
    check("empty_yes", 32'(yc), 0);
    check("empty_no", 32'(nc), 0);
    check("empty_res", 32'(res), 1);

    // Reset after 5 accepts discards the round.
    start_round();
    vv = '1; vb = 15'($urandom);
    repeat (5) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(vr), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_yes", 32'(yc), 0);
    check("mid_rst_no", 32'(nc), 0);
    @(posedge clk);
    check("mid_rst_rv", 32'(rv), 0);
    #1 rst = 1'b0;
    vv = '0;
    cycle();

    // Randomized rounds; each start lands in the previous round's result_valid cycle.
    repeat (30) begin
      tie = 1'($urandom);
      start_round();
      for (int c = 0; c < 40 && m_phase == 1; c++) begin
        vv    = 15'($urandom) & 15'($urandom);
        vb    = 15'($urandom);
        close = ($urandom_range(0, 19) == 0) || (c == 39);
        start = ($urandom_range(0, 7) == 0);
        cycle();
        start = 1'b0;
      end
      finish_round();
    end
    close = 1'b1;
    cycle();
    close = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks made", n_tests);
    $fatal(1);
  end
endmodule
